// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store, data first.
// Define FETCH_BUF_EN to add a one-entry fetch buffer that serves repeated fetches locally.
`timescale 1ns/1ps
module mem_port_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_done,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          stall_fetch,
   output logic          stall_data,
   output logic          mem_err
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [DW-1:0] AbortWord = DW'(32'hDEADBEEF);

   typedef enum logic [1:0] {StIdle, StFetch, StData, StResp} stateT;

   stateT         state;
   logic [CW-1:0] waitCnt;

`ifdef FETCH_BUF_EN
   logic          bufValid;
   logic [AW-1:0] bufTag;
   logic [DW-1:0] bufWord;
`endif

   assign stall_fetch = if_req && !if_valid;
   assign stall_data  = d_req && !d_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         waitCnt   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_valid  <= 1'b0;
         d_done    <= 1'b0;
         mem_err   <= 1'b0;
`ifdef FETCH_BUF_EN
         bufValid  <= 1'b0;
         bufTag    <= '0;
         bufWord   <= '0;
`endif
      end else begin
         if_valid <= 1'b0;
         d_done   <= 1'b0;
         unique case (state)
            StIdle: begin
               waitCnt <= '0;
               if (d_req) begin
                  state     <= StData;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
               end
`ifdef FETCH_BUF_EN
               else if (if_req && bufValid && (bufTag == if_addr)) begin
                  state    <= StResp;
                  if_rdata <= bufWord;
                  if_valid <= 1'b1;
               end
`endif
               else if (if_req) begin
                  state    <= StFetch;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= if_addr;
               end
            end
            StFetch, StData: begin
               // An ack in the final counted cycle still completes normally.
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= StResp;
                  if (state == StFetch) begin
                     if_rdata <= mem_rdata;
                     if_valid <= 1'b1;
`ifdef FETCH_BUF_EN
                     bufValid <= 1'b1;
                     bufTag   <= mem_addr;
                     bufWord  <= mem_rdata;
`endif
                  end else begin
                     d_rdata <= mem_rdata;
                     d_done  <= 1'b1;
`ifdef FETCH_BUF_EN
                     if (mem_we && (mem_addr == bufTag)) bufValid <= 1'b0;
`endif
                  end
               end else if (waitCnt == CW'(TIMEOUT - 1)) begin
                  mem_req <= 1'b0;
                  mem_err <= 1'b1;
                  state   <= StResp;
                  if (state == StFetch) begin
                     if_rdata <= AbortWord;
                     if_valid <= 1'b1;
                  end else begin
                     d_rdata <= AbortWord;
                     d_done  <= 1'b1;
                  end
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end
            StResp: state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF stage (fetch, read-only) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences each access with a req/ack handshake to the memory.
- Returns data to the winning requester.
- Drives stall_fetch and stall_data, which the hazard/stall logic uses to freeze the PC/IF-ID (fetch) or the whole pipeline (data).

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 255, maximum cycles in FETCH/DATA without mem_ack before the access is aborted; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  AW  fetch address; stable while if_req.
- if_rdata  out  DW  fetched word; valid when if_valid.
- if_valid  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid when d_done.
- d_done  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory access request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  AW  memory address, registered.
- mem_wdata  out  DW  memory write data, registered.
- mem_rdata  in  DW  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, single-cycle.
- stall_fetch  out  1  combinational: if_req && !if_valid.
- stall_data  out  1  combinational: d_req && !d_done.
- mem_err  out  1  sticky timeout flag.

Behaviour:

State machine, IDLE/FETCH/DATA/RESP, registered state:
- IDLE:
  - d_req → DATA; else if_req → FETCH. Data has fixed priority: the MEM-stage instruction is older.
  - On transition: latch address, we, and wdata into mem_*; set mem_req=1; clear timeout counter.
  - Fetch always drives mem_we=0.
- FETCH/DATA:
  - Hold mem_req and all mem_* outputs stable.
  - Count cycles.
  - On mem_ack: capture mem_rdata into if_rdata or d_rdata. A store still sets d_rdata to mem_rdata, which is don't-care. Then set mem_req=0 and go to RESP with the matching pulse armed.
  - If the count reaches TIMEOUT with no ack: set mem_req=0, set mem_err=1, load rdata with 32'hDEADBEEF, go to RESP. The requester is still completed, so the pipeline never hangs.
- RESP:
  - if_valid or d_done is high for exactly this one cycle.
  - No new grant is made in this cycle, even though the completed requester's req is still high.
  - Next state is IDLE.

Timing:
- Minimum latency: req sampled at edge 0 → mem_req high in cycle 1 → ack in cycle 1 → pulse in cycle 2.
- Back-to-back throughput is one access per (3 + memory wait) cycles.

Boundary conditions:
- Simultaneous if_req and d_req in IDLE: data is granted; fetch is served on the next IDLE if still requested.
- A new req arriving mid-access waits. It is never dropped.
- mem_ack while in IDLE or RESP is ignored.
- mem_ack in the same cycle the counter hits TIMEOUT: the ack wins and mem_err is unchanged.
- Timeout counter width is clog2(TIMEOUT+1).

Reset (asynchronous, at any point including mid-access):
- State → IDLE.
- mem_req, mem_we, if_valid, d_done, mem_err → 0.
- mem_addr, mem_wdata, if_rdata, d_rdata → 0.
- mem_req drops without waiting for a clock edge. A pending ack after reset is ignored.

Optional Feature:
- Macro FETCH_BUF_EN.
- When defined:
  - Add a one-entry fetch buffer: valid bit, tag (AW), and word, updated on every acked fetch.
  - In IDLE with only if_req pending, a valid buffer whose tag equals if_addr → go directly to RESP with if_rdata = buffered word. No memory access occurs.
  - An acked store to an address equal to the tag clears the buffer valid bit.
  - rst clears the valid bit.
- When undefined: no buffer logic; every fetch goes to memory.

Test Plan:
1. if_req=1, if_addr=0x0000_0040; memory acks 2 cycles after mem_req with 0x2008_0005 → mem_addr=0x40, mem_we=0; if_valid pulses exactly once with if_rdata=0x2008_0005; stall_fetch high until that cycle.
2. if_req and d_req (d_we=0, d_addr=0x100) rise in the same cycle → first mem_addr=0x100; d_done precedes if_valid; the fetch is granted only after RESP.
3. Store d_we=1, d_addr=0x200, d_wdata=0xCAFEF00D, immediate ack → mem_we=1, mem_wdata=0xCAFEF00D; d_done pulse in cycle 2; stall_data low after it.
4. TIMEOUT=4, data load, no ack → mem_req drops after 4 cycles; d_done with d_rdata=0xDEADBEEF; mem_err=1 and stays 1 until rst.
5. rst asserted asynchronously mid-FETCH, ack arrives 1 cycle later → mem_req=0 immediately; no if_valid; all outputs 0; a subsequent fetch completes normally.
6. With FETCH_BUF_EN defined: fetch 0x40 twice → the second fetch has no mem_req and if_valid comes one cycle after the request. A store to 0x40 followed by a fetch of 0x40 → mem_req is issued again.
